// File: rtl/oc8051_ecall_ctrl_pkg.sv
// Shared constants for the ecall/eret trap sequencer: SFR addresses and
// FSM state encoding.
package oc8051_ecall_ctrl_pkg;

  localparam logic [7:0] OC8051_SFR_ECAUSE = 8'hED;
  localparam logic [7:0] OC8051_SFR_EPC_LO = 8'hEE;
  localparam logic [7:0] OC8051_SFR_EPC_HI = 8'hEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TJUMP = 2'd1,
    RJUMP = 2'd2
  } ecall_state_e;

endpackage

// File: rtl/oc8051_epc_sfr.sv
// Privileged byte-writable register with a trap-load port. The trap load
// takes priority over an SFR write in the same cycle. Bit-addressed writes
// are ignored. W must be in 9..16: the low byte is bits [7:0] and the
// high byte is bits [W-1:8].
module oc8051_epc_sfr
  import oc8051_ecall_ctrl_pkg::*;
#(
  parameter int         W       = 16,
  parameter logic [7:0] LO_ADDR = OC8051_SFR_EPC_LO,
  parameter logic [7:0] HI_ADDR = OC8051_SFR_EPC_HI
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         priv,
  input  logic         wr,
  input  logic         wr_bit,
  input  logic [7:0]   wr_addr,
  input  logic [7:0]   data_in,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);

  logic byte_wr;
  assign byte_wr = priv & wr & ~wr_bit;

  // Register update: reset, then trap load, then byte writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (byte_wr && wr_addr == LO_ADDR) begin
      q[7:0] <= data_in;
    end else if (byte_wr && wr_addr == HI_ADDR) begin
      q[W-1:8] <= data_in[W-9:0];
    end
  end

endmodule

// File: rtl/oc8051_ecall_ctrl.sv
// Trap sequencer for ecall/eret. Owns the privilege flag and EPC, and
// drives a PC redirect handshake (pc_load held until pc_ack).
// Optional feature: define OC8051_ECALL_CAUSE_EN to add the ECAUSE SFR
// latched from ecall_code on ecall entry.
module oc8051_ecall_ctrl
  import oc8051_ecall_ctrl_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ecall_req,
  input  logic            eret_req,
  input  logic [PC_W-1:0] pc_next,
  input  logic [PC_W-1:0] etr,
  input  logic            pc_ack,
  input  logic            wr,
  input  logic            wr_bit,
  input  logic [7:0]      wr_addr,
  input  logic [7:0]      data_in,
  input  logic [7:0]      rd_addr,
  input  logic [7:0]      ecall_code,
  output logic            priv_lvl,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_target,
  output logic            busy,
  output logic            fault,
  output logic [7:0]      data_out,
  output logic [PC_W-1:0] epc
);

  ecall_state_e state, state_d;
  logic         priv_d;
  logic         fault_d;
  logic         trap_save;

  oc8051_epc_sfr #(
    .W       (PC_W),
    .LO_ADDR (OC8051_SFR_EPC_LO),
    .HI_ADDR (OC8051_SFR_EPC_HI)
  ) u_epc (
    .clk      (clk),
    .rst      (rst),
    .priv     (priv_lvl),
    .wr       (wr),
    .wr_bit   (wr_bit),
    .wr_addr  (wr_addr),
    .data_in  (data_in),
    .load     (trap_save),
    .load_val (pc_next),
    .q        (epc)
  );

  // State, privilege and fault registers; boot privileged.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      priv_lvl <= 1'b1;
      fault    <= 1'b0;
    end else begin
      state    <= state_d;
      priv_lvl <= priv_d;
      fault    <= fault_d;
    end
  end

  // Next-state, privilege change, fault detection and redirect outputs.
  always_comb begin
    state_d   = state;
    priv_d    = priv_lvl;
    fault_d   = 1'b0;
    trap_save = 1'b0;
    pc_load   = 1'b0;
    pc_target = '0;
    case (state)
      IDLE: begin
        if (ecall_req && eret_req) begin
          fault_d = 1'b1;
        end else if (ecall_req) begin
          if (priv_lvl) begin
            fault_d = 1'b1;
          end else begin
            trap_save = 1'b1;
            priv_d    = 1'b1;
            state_d   = TJUMP;
          end
        end else if (eret_req) begin
          if (!priv_lvl) fault_d = 1'b1;
          else           state_d = RJUMP;
        end
      end
      TJUMP: begin
        pc_load   = 1'b1;
        pc_target = etr;
        if (pc_ack) state_d = IDLE;
      end
      RJUMP: begin
        pc_load   = 1'b1;
        pc_target = epc;
        if (pc_ack) begin
          priv_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef OC8051_ECALL_CAUSE_EN
  logic [7:0] ecause;

  // Cause register: latched with the EPC save, otherwise privileged byte write.
  always_ff @(posedge clk) begin
    if (rst) begin
      ecause <= 8'h00;
    end else if (trap_save) begin
      ecause <= ecall_code;
    end else if (priv_lvl && wr && !wr_bit && wr_addr == OC8051_SFR_ECAUSE) begin
      ecause <= data_in;
    end
  end
`else
  logic unused_code;
  assign unused_code = ^ecall_code;
`endif

  // Combinational SFR read; user mode and unmapped addresses read zero.
  always_comb begin
    data_out = 8'h00;
    if (priv_lvl) begin
      case (rd_addr)
        OC8051_SFR_EPC_LO: data_out = epc[7:0];
        OC8051_SFR_EPC_HI: data_out = {{(16-PC_W){1'b0}}, epc[PC_W-1:8]};
`ifdef OC8051_ECALL_CAUSE_EN
        OC8051_SFR_ECAUSE: data_out = ecause;
`endif
        default:           data_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_oc8051_ecall_ctrl.sv
// Directed bench for oc8051_ecall_ctrl: reset, ecall/eret sequences,
// SFR access, illegal requests, reset mid-sequence and the cause SFR.
module tb_oc8051_ecall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ecall_req, eret_req, pc_ack, wr, wr_bit;
  logic [15:0] pc_next, etr;
  logic [7:0]  wr_addr, data_in, rd_addr, ecall_code;
  logic        priv_lvl, pc_load, busy, fault;
  logic [15:0] pc_target, epc;
  logic [7:0]  data_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  oc8051_ecall_ctrl #(.PC_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .ecall_req  (ecall_req),
    .eret_req   (eret_req),
    .pc_next    (pc_next),
    .etr        (etr),
    .pc_ack     (pc_ack),
    .wr         (wr),
    .wr_bit     (wr_bit),
    .wr_addr    (wr_addr),
    .data_in    (data_in),
    .rd_addr    (rd_addr),
    .ecall_code (ecall_code),
    .priv_lvl   (priv_lvl),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .busy       (busy),
    .fault      (fault),
    .data_out   (data_out),
    .epc        (epc)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 2 ns later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; ecall_req = 0; eret_req = 0; pc_ack = 0; wr = 0; wr_bit = 0;
    pc_next = 16'h0; etr = 16'h0; wr_addr = 8'h0; data_in = 8'h0;
    rd_addr = 8'hEE; ecall_code = 8'h00;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_priv", {15'd0, priv_lvl}, 16'd1);
    check("rst_epc", epc, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_pcload", {15'd0, pc_load}, 16'd0);
    check("rst_fault", {15'd0, fault}, 16'd0);
    check("rst_dout", {8'd0, data_out}, 16'h0000);

    // eret from boot privilege, ack on the second RJUMP cycle
    eret_req = 1; step(); eret_req = 0; #1;
    check("eret0_busy", {15'd0, busy}, 16'd1);
    check("eret0_load1", {15'd0, pc_load}, 16'd1);
    check("eret0_tgt1", pc_target, 16'h0000);
    check("eret0_priv_hold", {15'd0, priv_lvl}, 16'd1);
    step();
    check("eret0_load2", {15'd0, pc_load}, 16'd1);
    check("eret0_tgt2", pc_target, 16'h0000);
    pc_ack = 1; step(); pc_ack = 0; #1;
    check("eret0_priv", {15'd0, priv_lvl}, 16'd0);
    check("eret0_idle", {15'd0, busy}, 16'd0);
    check("eret0_unload", {15'd0, pc_load}, 16'd0);

    // user ecall, ack on the third TJUMP cycle, etr change honoured at once
    pc_next = 16'h1234; etr = 16'hA000; ecall_code = 8'h07;
    ecall_req = 1; step(); ecall_req = 0; ecall_code = 8'h00; #1;
    check("ecall_epc", epc, 16'h1234);
    check("ecall_priv", {15'd0, priv_lvl}, 16'd1);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin etr = 16'hB000; #1; end
      check("ecall_busy", {15'd0, busy}, 16'd1);
      check("ecall_load", {15'd0, pc_load}, 16'd1);
      check("ecall_tgt", pc_target, (i == 0) ? 16'hA000 : 16'hB000);
      if (i == 2) pc_ack = 1;
      step();
    end
    pc_ack = 0; #1;
    check("ecall_done_busy", {15'd0, busy}, 16'd0);
    check("ecall_done_load", {15'd0, pc_load}, 16'd0);
    check("ecall_done_tgt", pc_target, 16'h0000);

    // cause SFR read while privileged
    rd_addr = 8'hED; #1;
`ifdef OC8051_ECALL_CAUSE_EN
    check("cause_rd", {8'd0, data_out}, 16'h0007);
`else
    check("cause_rd", {8'd0, data_out}, 16'h0000);
`endif

    // privileged byte write, bit write ignored, then eret to EPC
    wr = 1; wr_addr = 8'hEE; data_in = 8'h56; step();
    wr_bit = 1; wr_addr = 8'hEF; data_in = 8'h99; step();
    wr = 0; wr_bit = 0; #1;
    check("wr_lo_epc", epc, 16'h1256);
    rd_addr = 8'hEE; #1;
    check("rd_lo", {8'd0, data_out}, 16'h0056);
    rd_addr = 8'hEF; #1;
    check("rd_hi", {8'd0, data_out}, 16'h0012);
    rd_addr = 8'h80; #1;
    check("rd_unmapped", {8'd0, data_out}, 16'h0000);
    eret_req = 1; step(); eret_req = 0; #1;
    check("eret1_tgt", pc_target, 16'h1256);
    pc_ack = 1; step(); pc_ack = 0; #1;
    check("eret1_priv", {15'd0, priv_lvl}, 16'd0);

    // eret while user: fault for one cycle only
    eret_req = 1; step(); eret_req = 0; #1;
    check("ill_eret_fault", {15'd0, fault}, 16'd1);
    check("ill_eret_busy", {15'd0, busy}, 16'd0);
    check("ill_eret_priv", {15'd0, priv_lvl}, 16'd0);
    step();
    check("ill_eret_fault_clr", {15'd0, fault}, 16'd0);

    // user write/read of EPC_HI has no effect
    wr = 1; wr_addr = 8'hEF; data_in = 8'hFF; rd_addr = 8'hEF; step(); wr = 0; #1;
    check("user_wr_epc", epc, 16'h1256);
    check("user_rd", {8'd0, data_out}, 16'h0000);

    // user ecall with immediate ack, regains privilege
    pc_next = 16'h4321; etr = 16'hA000;
    ecall_req = 1; step(); ecall_req = 0; pc_ack = 1; step(); pc_ack = 0; #1;
    check("ecall2_epc", epc, 16'h4321);
    check("ecall2_busy", {15'd0, busy}, 16'd0);

    // ecall while privileged
    pc_next = 16'h5555;
    ecall_req = 1; step(); ecall_req = 0; #1;
    check("ill_ecall_fault", {15'd0, fault}, 16'd1);
    check("ill_ecall_busy", {15'd0, busy}, 16'd0);
    check("ill_ecall_epc", epc, 16'h4321);
    check("ill_ecall_priv", {15'd0, priv_lvl}, 16'd1);
    step();
    check("ill_ecall_fault_clr", {15'd0, fault}, 16'd0);

    // simultaneous ecall + eret
    ecall_req = 1; eret_req = 1; step(); ecall_req = 0; eret_req = 0; #1;
    check("ill_both_fault", {15'd0, fault}, 16'd1);
    check("ill_both_busy", {15'd0, busy}, 16'd0);
    check("ill_both_epc", epc, 16'h4321);
    step();
    check("ill_both_fault_clr", {15'd0, fault}, 16'd0);

    // drop to user, enter TJUMP, then reset mid-sequence
    eret_req = 1; step(); eret_req = 0; pc_ack = 1; step(); pc_ack = 0; #1;
    check("pre_rst_priv", {15'd0, priv_lvl}, 16'd0);
    ecall_req = 1; step(); ecall_req = 0; #1;
    check("pre_rst_load", {15'd0, pc_load}, 16'd1);
    rst = 1; step(); rst = 0; #1;
    check("rst_tj_load", {15'd0, pc_load}, 16'd0);
    check("rst_tj_priv", {15'd0, priv_lvl}, 16'd1);
    check("rst_tj_busy", {15'd0, busy}, 16'd0);
    check("rst_tj_epc", epc, 16'h0000);
    step();
    check("rst_tj_load2", {15'd0, pc_load}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
